// File: rtl/clock_pkg.sv
// Shared definitions for the 24h clock: time-setting mode encodings and mode stepping.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_t;

    // MODE key cycles RUN -> SET_HOUR -> SET_MIN -> RUN; the unused code recovers to RUN.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_RUN:      next_mode = MODE_SET_HOUR;
            MODE_SET_HOUR: next_mode = MODE_SET_MIN;
            default:       next_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw key synchroniser and debouncer: level follows the key after DEB_CYCLES stable samples,
// key_rise pulses for one cycle when the debounced level goes high.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_lvl,
    output logic key_rise
);

    localparam int unsigned CntW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            lvl_q, lvl_d;
    logic            rise_q, rise_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        cnt_d  = '0;
        // Count consecutive samples disagreeing with the current level; any agreement restarts.
        if (sync2_q != lvl_q) begin
            if (32'(cnt_q) + 32'd1 >= DEB_CYCLES) begin
                lvl_d  = sync2_q;
                rise_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_lvl  = lvl_q;
    assign key_rise = rise_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode FSM, idle timeout, INC auto-repeat, one-shot hour/minute
// correction flags for the 1 Hz counter domain, and digit blink blanking.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 20,
    parameter int unsigned REPEAT_DELAY = 2,
    parameter int unsigned TIMEOUT_S    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [1:0] mode,
    output logic       hour_correct,
    output logic       min_correct,
    output logic       blank_hour,
    output logic       blank_min
);

    localparam int unsigned IdleW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);
    localparam int unsigned RepW  = (REPEAT_DELAY < 2) ? 1 : $clog2(REPEAT_DELAY + 1);

    logic mode_lvl, mode_rise;
    logic inc_lvl, inc_rise;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_mode),
        .key_lvl  (mode_lvl),
        .key_rise (mode_rise)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_inc),
        .key_lvl  (inc_lvl),
        .key_rise (inc_rise)
    );

    mode_t            mode_q, mode_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [RepW-1:0]  rep_q, rep_d;
    logic             pend_h_q, pend_h_d;
    logic             pend_m_q, pend_m_d;
    logic             phase_q, phase_d;

    logic in_set, mode_evt, rep_fire, inc_evt, timeout, mode_chg;

    always_comb begin
        in_set   = (mode_q != MODE_RUN);
        mode_evt = mode_rise;
        // The tick that completes the hold delay already produces the first repeat step.
        rep_fire = tick_1hz & inc_lvl & in_set & (32'(rep_q) + 32'd1 >= REPEAT_DELAY);
        inc_evt  = (inc_rise | rep_fire) & ~mode_evt;
        timeout  = in_set & tick_1hz & ~mode_evt & ~inc_evt
                 & (32'(idle_q) + 32'd1 >= TIMEOUT_S);
        mode_chg = mode_evt | timeout;

        mode_d = mode_q;
        if (mode_evt) begin
            mode_d = next_mode(mode_q);
        end else if (timeout) begin
            mode_d = MODE_RUN;
        end

        idle_d = idle_q;
        if (!in_set || mode_chg || inc_evt) begin
            idle_d = '0;
        end else if (tick_1hz) begin
            idle_d = idle_q + IdleW'(1);
        end

        rep_d = rep_q;
        if (!in_set || mode_chg || !inc_lvl) begin
            rep_d = '0;
        end else if (tick_1hz && (32'(rep_q) < REPEAT_DELAY)) begin
            rep_d = rep_q + RepW'(1);
        end

        // A tick consumes the flag; an event in the same cycle re-arms it for the next second.
        pend_h_d = (pend_h_q & ~tick_1hz) | (inc_evt & (mode_q == MODE_SET_HOUR));
        pend_m_d = (pend_m_q & ~tick_1hz) | (inc_evt & (mode_q == MODE_SET_MIN));

        phase_d = phase_q;
        if (mode_chg) begin
            phase_d = 1'b0;
        end else if (tick_1hz) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_RUN;
            idle_q   <= '0;
            rep_q    <= '0;
            pend_h_q <= 1'b0;
            pend_m_q <= 1'b0;
            phase_q  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            idle_q   <= idle_d;
            rep_q    <= rep_d;
            pend_h_q <= pend_h_d;
            pend_m_q <= pend_m_d;
            phase_q  <= phase_d;
        end
    end

    assign mode         = mode_q;
    assign hour_correct = pend_h_q;
    assign min_correct  = pend_m_q;
    assign blank_hour   = (mode_q == MODE_SET_HOUR) & phase_q & ~inc_lvl;
    assign blank_min    = (mode_q == MODE_SET_MIN) & phase_q & ~inc_lvl;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues timestamped expectations,
// a negedge monitor pops and compares them and counts delivered corrections.
module tb_clock_set_ctrl;

    localparam int F_MODE = 0;
    localparam int F_HC   = 1;
    localparam int F_MC   = 2;
    localparam int F_BH   = 3;
    localparam int F_BM   = 4;
    localparam int F_HDEL = 5;
    localparam int F_MDEL = 6;

    typedef struct {
        string name;
        int    due;
        int    field;
        int    value;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       key_mode;
    logic       key_inc;
    logic [1:0] mode;
    logic       hour_correct;
    logic       min_correct;
    logic       blank_hour;
    logic       blank_min;

    clock_set_ctrl #(
        .DEB_CYCLES   (20),
        .REPEAT_DELAY (2),
        .TIMEOUT_S    (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .key_mode     (key_mode),
        .key_inc      (key_inc),
        .mode         (mode),
        .hour_correct (hour_correct),
        .min_correct  (min_correct),
        .blank_hour   (blank_hour),
        .blank_min    (blank_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   h_del = 0;
    int   m_del = 0;
    bit   drain_req = 1'b0;
    bit   drain_done = 1'b0;
    exp_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input int f);
        case (f)
            F_MODE:  actual = int'(mode);
            F_HC:    actual = int'(hour_correct);
            F_MC:    actual = int'(min_correct);
            F_BH:    actual = int'(blank_hour);
            F_BM:    actual = int'(blank_min);
            F_HDEL:  actual = h_del;
            default: actual = m_del;
        endcase
    endfunction

    // Monitor: compare due expectations, then tally corrections seen across a 1 Hz edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   act;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e   = sb_q.pop_front();
            act = actual(e.field);
            checks++;
            if (act != e.value) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, act, e.value, cyc);
            end
        end
        if (tick_1hz && hour_correct) h_del++;
        if (tick_1hz && min_correct)  m_del++;
        if (drain_req && !drain_done) begin
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations never compared, expected 0", sb_q.size());
            end
            drain_done = 1'b1;
        end
    end

    task automatic expect_now(input string nm, input int f, input int v);
        exp_t e;
        e.name  = nm;
        e.due   = cyc;
        e.field = f;
        e.value = v;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
    endtask

    task automatic press_mode();
        key_mode = 1'b1;
        step(30);
        key_mode = 1'b0;
        step(30);
    endtask

    task automatic press_inc();
        key_inc = 1'b1;
        step(30);
        key_inc = 1'b0;
        step(30);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        tick_1hz = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset state, then quiet hold with no ticks
        expect_now("rst_mode", F_MODE, 0);
        expect_now("rst_hc", F_HC, 0);
        expect_now("rst_mc", F_MC, 0);
        expect_now("rst_bh", F_BH, 0);
        expect_now("rst_bm", F_BM, 0);
        step(100);
        expect_now("quiet_mode", F_MODE, 0);
        expect_now("quiet_hc", F_HC, 0);

        // Glitches before a clean MODE press give exactly one step
        repeat (2) begin
            key_mode = 1'b1;
            step(3);
            key_mode = 1'b0;
            step(3);
        end
        press_mode();
        expect_now("mode_step1", F_MODE, 1);
        press_mode();
        expect_now("mode_step2", F_MODE, 2);
        press_mode();
        expect_now("mode_step3", F_MODE, 0);

        // SET_HOUR: one INC press delivers exactly one hour correction
        press_mode();
        expect_now("t3_mode", F_MODE, 1);
        key_inc = 1'b1;
        step(20);
        expect_now("hc_before_event", F_HC, 0);
        step(5);
        expect_now("hc_after_event", F_HC, 1);
        step(5);
        key_inc = 1'b0;
        step(30);
        expect_now("hc_held", F_HC, 1);
        expect_now("bh_phase0", F_BH, 0);
        expect_now("hc_at_tick1", F_HC, 1);
        pulse_tick();
        expect_now("hc_after_tick1", F_HC, 0);
        expect_now("bh_phase1", F_BH, 1);
        step(3);
        pulse_tick();
        expect_now("bh_phase0_again", F_BH, 0);
        step(2);
        expect_now("t3_h_del", F_HDEL, 1);
        expect_now("t3_m_del", F_MDEL, 0);

        // SET_MIN: INC held over 5 ticks, press plus auto-repeat
        press_mode();
        expect_now("t4_mode", F_MODE, 2);
        key_inc = 1'b1;
        step(30);
        expect_now("mc_press", F_MC, 1);
        for (int i = 0; i < 5; i++) begin
            expect_now($sformatf("mc_at_tick%0d", i + 1), F_MC, (i == 1) ? 0 : 1);
            pulse_tick();
            expect_now($sformatf("bm_held_tick%0d", i + 1), F_BM, 0);
            expect_now($sformatf("hc_quiet_tick%0d", i + 1), F_HC, 0);
            step(4);
        end
        key_inc = 1'b0;
        step(30);
        expect_now("mc_pending_after_release", F_MC, 1);
        expect_now("bm_released", F_BM, 1);
        expect_now("mc_at_tick6", F_MC, 1);
        pulse_tick();
        expect_now("mc_after_tick6", F_MC, 0);
        expect_now("bm_after_tick6", F_BM, 0);
        step(2);
        expect_now("t4_m_del", F_MDEL, 5);
        expect_now("t4_h_del", F_HDEL, 1);

        // Idle timeout from SET_HOUR after 10 ticks
        press_mode();
        expect_now("t5_run", F_MODE, 0);
        press_mode();
        expect_now("t5_mode", F_MODE, 1);
        for (int i = 1; i <= 10; i++) begin
            pulse_tick();
            if (i < 10) begin
                expect_now($sformatf("t5_mode_tick%0d", i), F_MODE, 1);
                expect_now($sformatf("t5_bh_tick%0d", i), F_BH, i % 2);
            end else begin
                expect_now("t5_timeout_mode", F_MODE, 0);
                expect_now("t5_timeout_bh", F_BH, 0);
            end
            step(3);
        end

        // Reset discards a pending hour correction
        press_mode();
        expect_now("t6_mode", F_MODE, 1);
        press_inc();
        expect_now("t6_hc_pending", F_HC, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_now("t6_hc_after_rst", F_HC, 0);
        expect_now("t6_mode_after_rst", F_MODE, 0);
        step(3);
        expect_now("t6_hc_at_tick", F_HC, 0);
        pulse_tick();
        step(2);
        expect_now("t6_h_del", F_HDEL, 1);

        step(2);
        drain_req = 1'b1;
        for (int i = 0; i < 10 && !drain_done; i++) step(1);
        if (!drain_done) begin
            $display("FAIL drain_timeout: monitor did not respond, expected completion");
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
